// File: rtl/mat4x4x2_seq_ctrl_pkg.sv
// Shared types and constants for the 4x4-by-4x2 sequenced matrix multiplier.
package mat_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } seqState_t;

  localparam int N_A   = 16;
  localparam int N_B   = 8;
  localparam int N_S   = 8;
  localparam int K_DIM = 4;

  // Derived sizes: operand words per job and MAC cycles per job.
  localparam int N_OPS = N_A + N_B;
  localparam int N_MAC = N_S * K_DIM;

  localparam logic [15:0] SAT_MAX = 16'h7fff;
  localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/mat4x4x2_seq_ctrl_if.sv
// Operand/result stream bundle; the controller is the slave side.
interface mat4x4x2_seq_ctrl_if #(
  parameter int DW = 16
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    out_idx;
  logic          out_last;
  logic          busy;
  logic          done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy, done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy, done
  );

endinterface

// File: rtl/mat4x4x2_seq_ctrl_q_mac.sv
// Shared signed Q8.8 multiply-accumulate with floor shift and saturation.
// o_result always shows sat(floor((base + a*b) >>> FRAC)), where base is
// zero on a clear cycle and the running accumulator otherwise, so the
// controller can capture the finished dot product on the last term.
module q_mac
  import mat_seq_pkg::*;
#(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_clear,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  output logic        [DW-1:0] o_result
);

  localparam logic signed [ACC_W-1:0] LIM_HI = {{(ACC_W-16){SAT_MAX[15]}}, SAT_MAX};
  localparam logic signed [ACC_W-1:0] LIM_LO = {{(ACC_W-16){SAT_MIN[15]}}, SAT_MIN};

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] r_acc;

  // Product, running sum, arithmetic shift and clamp to the Q8.8 range.
  always_comb begin
    w_prod    = i_a * i_b;
    w_base    = i_clear ? '0 : r_acc;
    w_sum     = w_base + {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    w_shifted = w_sum >>> FRAC;
    if (w_shifted > LIM_HI) begin
      o_result = SAT_MAX;
    end else if (w_shifted < LIM_LO) begin
      o_result = SAT_MIN;
    end else begin
      o_result = w_shifted[DW-1:0];
    end
  end

  // Accumulator register, updated on every enabled MAC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/mat4x4x2_seq_ctrl.sv
// Sequencing controller: loads A(4x4) and B(4x2), runs 32 MAC cycles on one
// shared q_mac, then streams S(4x2) out in row-major order.
module mat4x4x2_seq_ctrl
  import mat_seq_pkg::*;
#(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic                clk,
  input  logic                rst,
  mat4x4x2_seq_ctrl_if.slave  io
);

  seqState_t r_state;
  seqState_t w_nextState;

  logic [4:0]    r_loadCnt;
  logic [4:0]    r_macCnt;
  logic [2:0]    r_idx;
  logic [DW-1:0] r_regFile [N_OPS];
  logic [DW-1:0] r_rbuf    [N_S];

  logic          w_inXfer;
  logic          w_outXfer;
  logic          w_loadLast;
  logic          w_macLast;
  logic          w_outLast;
  logic [2:0]    w_j;
  logic [1:0]    w_k;
  logic [4:0]    w_aIdx;
  logic [4:0]    w_bIdx;
  logic [DW-1:0] w_macResult;

  // Handshake qualifiers and operand addressing for the current MAC step;
  // A sits at 0..15 and B at 16..23 of the register file.
  always_comb begin
    w_inXfer   = (r_state == LOAD) && io.in_valid;
    w_outXfer  = (r_state == DRAIN) && io.out_ready;
    w_loadLast = (r_loadCnt == 5'(N_OPS - 1));
    w_macLast  = (r_macCnt == 5'(N_MAC - 1));
    w_outLast  = (r_idx == 3'(N_S - 1));
    w_j        = r_macCnt[4:2];
    w_k        = r_macCnt[1:0];
    w_aIdx     = {1'b0, w_j[2:1], w_k};
    w_bIdx     = {2'b10, w_k, w_j[0]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    w_nextState = LOAD;
      LOAD:    if (w_inXfer && w_loadLast) w_nextState = COMPUTE;
      COMPUTE: if (w_macLast) w_nextState = DRAIN;
      DRAIN:   if (w_outXfer && w_outLast) w_nextState = LOAD;
      default: w_nextState = IDLE;
    endcase
  end

  // Load, MAC and drain counters; each wraps to 0 at the end of its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loadCnt <= '0;
      r_macCnt  <= '0;
      r_idx     <= '0;
    end else begin
      if (w_inXfer) begin
        r_loadCnt <= w_loadLast ? 5'd0 : r_loadCnt + 5'd1;
      end
      if (r_state == COMPUTE) begin
        r_macCnt <= r_macCnt + 5'd1;
      end
      if (w_outXfer) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  // Operand register file, written in arrival order.
  always_ff @(posedge clk) begin
    if (w_inXfer) begin
      r_regFile[r_loadCnt] <= io.in_data;
    end
  end

  // Capture each finished dot product on its last inner-loop term.
  always_ff @(posedge clk) begin
    if ((r_state == COMPUTE) && (w_k == 2'd3)) begin
      r_rbuf[w_j] <= w_macResult;
    end
  end

  q_mac #(
    .DW    (DW),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_state == COMPUTE),
    .i_clear  (w_k == 2'd0),
    .i_a      (r_regFile[w_aIdx]),
    .i_b      (r_regFile[w_bIdx]),
    .o_result (w_macResult)
  );

  // Stream outputs decoded from state so reset returns them to zero at once.
  always_comb begin
    io.in_ready  = (r_state == LOAD);
    io.out_valid = (r_state == DRAIN);
    io.out_data  = (r_state == DRAIN) ? r_rbuf[r_idx] : '0;
    io.out_idx   = r_idx;
    io.out_last  = (r_state == DRAIN) && w_outLast;
    io.busy      = (r_state == COMPUTE) || (r_state == DRAIN);
    io.done      = w_outXfer && w_outLast;
  end

endmodule

// File: tb/tb_mat4x4x2_seq_ctrl.sv
// Self-checking bench: streams operand sets, predicts results with a
// behavioural matrix model into a scoreboard queue, and checks the result
// stream, latency, handshake stalls and mid-operation reset.
module tb_mat4x4x2_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mat4x4x2_seq_ctrl_if #(.DW(16)) bus ();

  mat4x4x2_seq_ctrl #(
    .DW    (16),
    .FRAC  (8),
    .ACC_W (40)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int          checkCnt = 0;
  int          errCnt   = 0;
  logic [15:0] opA [16];
  logic [15:0] opB [8];
  logic [15:0] expQ [$];
  logic [15:0] gotS [8];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    if (observed !== expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference result: exact integer dot product, floor shift, clamp.
  function automatic logic [15:0] modelS(input int r, input int c);
    longint sum;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      sum += longint'($signed(opA[4*r+k])) * longint'($signed(opB[2*k+c]));
    end
    sum = sum >>> 8;
    if (sum > 32767) return 16'h7fff;
    if (sum < -32768) return 16'h8000;
    return 16'(sum);
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, {8'd0, bus.in_ready, bus.out_valid, bus.out_data, bus.out_idx,
                      bus.out_last, bus.busy, bus.done}, 32'd0);
  endtask

  task automatic setA(input logic [15:0] v [16]);
    for (int i = 0; i < 16; i++) opA[i] = v[i];
  endtask

  task automatic setB(input logic [15:0] v [8]);
    for (int i = 0; i < 8; i++) opB[i] = v[i];
  endtask

  task automatic clearOps();
    for (int i = 0; i < 16; i++) opA[i] = 16'h0000;
    for (int i = 0; i < 8; i++) opB[i] = 16'h0000;
  endtask

  // Streams the 24 operand words and queues the expected results; returns
  // right after the clock edge that carries the 24th transfer.
  task automatic applyStimulus(input bit useGaps);
    int  i;
    int  cyc;
    bit  gap;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) expQ.push_back(modelS(r, c));
    end
    i   = 0;
    cyc = 0;
    while (i < 24 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      gap = useGaps && ($urandom_range(0, 2) == 0);
      if (gap) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hdead;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = (i < 16) ? opA[i] : opB[i-16];
        if (bus.in_ready) i++;
      end
    end
    if (i < 24) checkOutput("load_timeout", i, 24);
    @(posedge clk);
  endtask

  // Counts cycles from the 24th transfer to the first valid result.
  task automatic waitFirstResult(input bit checkLat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
      if (lat == 1) begin
        checkOutput("in_ready_drop", bus.in_ready, 0);
        checkOutput("busy_compute", bus.busy, 1);
      end
    end while (!bus.out_valid && lat < 100);
    if (checkLat) checkOutput("latency", lat, 33);
    else if (!bus.out_valid) checkOutput("first_result_timeout", lat, 33);
  endtask

  // Accepts results up to stopAt, optionally stalling 5 cycles at idx 3
  // and toggling out_ready afterwards; entered at a negedge with out_valid.
  task automatic drainResults(input bit stall, input int stopAt);
    int          got;
    int          cyc;
    int          stallLeft;
    bit          toggle;
    bit          prevStall;
    bit          rdy;
    logic [15:0] prevData;
    logic [2:0]  prevIdx;
    logic [15:0] expVal;
    got = 0; cyc = 0; stallLeft = 5; toggle = 1'b0; prevStall = 1'b0;
    prevData = '0; prevIdx = '0;
    while (got < stopAt && cyc < 300) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (prevStall) begin
        checkOutput("stall_data", bus.out_data, prevData);
        checkOutput("stall_idx", bus.out_idx, prevIdx);
      end
      if (!stall) begin
        rdy = 1'b1;
      end else if (bus.out_idx == 3'd3 && stallLeft > 0) begin
        rdy = 1'b0;
        stallLeft--;
      end else if (stallLeft == 0) begin
        rdy    = toggle;
        toggle = ~toggle;
      end else begin
        rdy = 1'b1;
      end
      bus.out_ready = rdy;
      #1;
      if (bus.out_valid && rdy) begin
        expVal = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
        checkOutput($sformatf("out_data[%0d]", got), bus.out_data, expVal);
        checkOutput("out_idx", bus.out_idx, got);
        checkOutput("out_last", bus.out_last, (got == 7));
        checkOutput("done", bus.done, (got == 7));
        gotS[got] = bus.out_data;
        got++;
      end
      prevStall = bus.out_valid && !rdy;
      prevData  = bus.out_data;
      prevIdx   = bus.out_idx;
    end
    if (got < stopAt) checkOutput("drain_timeout", got, stopAt);
    if (stopAt == 8) begin
      @(negedge clk);
      checkOutput("out_valid_after", bus.out_valid, 0);
      checkOutput("back_to_load", bus.in_ready, 1);
      checkOutput("done_single", bus.done, 0);
      checkOutput("queue_empty", expQ.size(), 0);
    end
  endtask

  logic [15:0] matA  [16] = '{16'h0080, 16'h0180, 16'hfe80, 16'hfe80,
                              16'h0080, 16'hfc80, 16'hfe80, 16'hfe80,
                              16'hfe80, 16'h0180, 16'hfc80, 16'h0180,
                              16'hfc80, 16'hfc80, 16'h0080, 16'hfc80};
  logic [15:0] matB1 [8]  = '{16'hfc80, 16'hfc80, 16'hfc80, 16'hfc80,
                              16'h0080, 16'hfc80, 16'hfc80, 16'hfc80};
  logic [15:0] matB2 [8]  = '{16'hff00, 16'hff00, 16'h0100, 16'hfe00,
                              16'h0100, 16'hff00, 16'h0100, 16'hff00};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_to_load", bus.in_ready, 1);

    $display("[TB] A x B1, continuous stream");
    setA(matA); setB(matB1);
    applyStimulus(1'b0);
    waitFirstResult(1'b1);
    drainResults(1'b0, 8);
    checkOutput("B1_S0", gotS[0], 16'hfd80);
    checkOutput("B1_S1", gotS[1], 16'h0380);
    checkOutput("B1_S6", gotS[6], 16'h2500);
    checkOutput("B1_S7", gotS[7], 16'h2300);

    $display("[TB] A x B2, back to back");
    setB(matB2);
    applyStimulus(1'b0);
    waitFirstResult(1'b1);
    drainResults(1'b0, 8);
    checkOutput("B2_S0", gotS[0], 16'hfe00);
    checkOutput("B2_S1", gotS[1], 16'hff80);

    opB[6] = 16'h0300;
    applyStimulus(1'b0);
    waitFirstResult(1'b1);
    drainResults(1'b0, 8);
    checkOutput("B2mod_S0", gotS[0], 16'hfb00);

    $display("[TB] saturation");
    clearOps();
    for (int k = 0; k < 4; k++) begin
      opA[k]     = 16'h7f00;
      opB[2*k]   = 16'h7f00;
    end
    applyStimulus(1'b0);
    waitFirstResult(1'b0);
    drainResults(1'b0, 8);
    checkOutput("sat_pos", gotS[0], 16'h7fff);
    for (int k = 0; k < 4; k++) opA[k] = 16'h8100;
    applyStimulus(1'b0);
    waitFirstResult(1'b0);
    drainResults(1'b0, 8);
    checkOutput("sat_neg", gotS[0], 16'h8000);

    $display("[TB] floor truncation");
    clearOps();
    opA[0] = 16'h0001; opB[0] = 16'h0001;
    applyStimulus(1'b0);
    waitFirstResult(1'b0);
    drainResults(1'b0, 8);
    checkOutput("floor_pos", gotS[0], 16'h0000);
    opA[0] = 16'hffff;
    applyStimulus(1'b0);
    waitFirstResult(1'b0);
    drainResults(1'b0, 8);
    checkOutput("floor_neg", gotS[0], 16'hffff);

    $display("[TB] input gaps and output stall");
    setA(matA); setB(matB1);
    applyStimulus(1'b1);
    waitFirstResult(1'b1);
    drainResults(1'b1, 8);
    checkOutput("gap_S0", gotS[0], 16'hfd80);
    checkOutput("gap_S7", gotS[7], 16'h2300);

    $display("[TB] reset during COMPUTE");
    applyStimulus(1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("reset_compute");
    rst = 1'b0;
    expQ.delete();

    $display("[TB] reset during DRAIN");
    applyStimulus(1'b0);
    waitFirstResult(1'b1);
    drainResults(1'b0, 2);
    @(negedge clk);
    checkOutput("abort_idx", bus.out_idx, 2);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("reset_drain");
    rst = 1'b0;
    expQ.delete();

    $display("[TB] fresh load after reset");
    bus.out_ready = 1'b1;
    setB(matB2);
    applyStimulus(1'b0);
    waitFirstResult(1'b1);
    drainResults(1'b0, 8);
    checkOutput("fresh_S0", gotS[0], 16'hfe00);

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/mat4x4x2_seq_ctrl.md
Name: mat4x4x2_seq_ctrl

Overview:
- Sequencing controller that computes S(4x2) = A(4x4) x B(4x2) in signed Q8.8 using one shared multiply-accumulate (MAC) unit. This is the time-multiplexed replacement for the fully combinational 4x4-by-4x2 multiplier array.
- Operands arrive as a valid/ready word stream.
- Results leave as a valid/ready word stream, in row-major order S0..S7.

Parameters:
- DW, 16, operand/result word width.
- FRAC, 8, number of fractional bits (Q8.8).
- ACC_W, 40, accumulator width; holds 4 full 2*DW products with no overflow.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller accepts an input word.
- in_data  in  DW  signed Q8.8 operand word.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DW  signed Q8.8 result word.
- out_idx  out  3  result index 0..7; S(2r+c) = row r, column c.
- out_last  out  1  high with out_idx==7.
- busy  out  1  high in COMPUTE or DRAIN.
- done  out  1  single-cycle pulse on acceptance of the last result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; all counters 0. Outputs in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
- States: IDLE, LOAD, COMPUTE, DRAIN.
  - IDLE -> LOAD unconditionally on the cycle after reset deasserts. In LOAD, in_ready=1.
- LOAD:
  - A word transfers when in_valid && in_ready.
  - 24 words arrive in this order: A0..A15 (row-major), then B0..B7 (row-major: B(2k+c) = row k, column c).
  - A 5-bit load counter writes the operand register file.
  - in_valid gaps are allowed; the counter holds during gaps.
  - On the 24th transfer, go to COMPUTE next cycle; in_ready drops in that same next cycle.
- COMPUTE:
  - Exactly 32 cycles, one MAC per cycle. Output index j = 0..7 (outer loop), k = 0..3 (inner loop).
  - Each cycle: prod = A[4*(j>>1)+k] * B[2*k+(j&1)], a full 2*DW signed product.
  - k==0: acc <= sign-extended prod.
  - k==1,2: acc <= acc + prod.
  - k==3: rbuf[j] <= sat(floor((acc+prod) >>> FRAC)).
    - Arithmetic shift, i.e. truncation toward minus infinity.
    - Saturate to [16'h8000, 16'h7fff].
  - After j=7, k=3, go to DRAIN.
- DRAIN:
  - out_valid=1 starting the cycle after the last COMPUTE cycle.
  - out_data=rbuf[idx], out_idx=idx.
  - idx advances only on out_valid && out_ready. out_data and out_idx stay stable while stalled.
  - On the transfer with idx==7: done=1 for one cycle, state -> LOAD, out_valid=0 next cycle.
- Latency: the first result is valid 33 cycles after the 24th input transfer; the last result follows 7 accepted transfers later at minimum.
- No overlap: in_ready=0 throughout COMPUTE and DRAIN. Input activity in those states is ignored.
- Reset in any state, including mid-COMPUTE or mid-DRAIN:
  - Aborts the operation; outputs return to reset values next cycle.
  - Partial operands and results are discarded, and the next load starts at A0.
  - Register file contents need not be cleared.

Decomposition:
- Package mat_seq_pkg holds:
  - the state enum (IDLE, LOAD, COMPUTE, DRAIN);
  - constants N_A=16, N_B=8, N_S=8, K_DIM=4;
  - the saturation limits SAT_MAX=16'h7fff and SAT_MIN=16'h8000.
- One sub-module, q_mac: signed DWxDW multiply, ACC_W accumulate with clear/accumulate control, and shift/saturate output. The controller owns the FSM, counters, register file and rbuf.

Test Plan:
- Operands, Q8.8, in row-major hex:
  - A (rows): 0080 0180 fe80 fe80 / 0080 fc80 fe80 fe80 / fe80 0180 fc80 0180 / fc80 fc80 0080 fc80.
  - B1 (rows): fc80 fc80 / fc80 fc80 / 0080 fc80 / fc80 fc80.
- A, then B1 streamed with in_valid continuously high and out_ready=1 -> results stream S0=fd80, S1=0380, S6=2500, S7=2300. out_valid rises exactly 33 cycles after the 24th transfer; done pulses with out_last.
- Same A, B2 = ff00 ff00 / 0100 fe00 / 0100 ff00 / 0100 ff00 -> S0=fe00, S1=ff80. Then repeat with B2 row 3 column 0 (B6) changed to 0300 -> S0=fb00. Also covers back-to-back operations.
- A0=7f00, A1..A3=7f00, column 0 of B=7f00, rest 0 -> S0=7fff (positive saturation). Negate A row 0 (8100) -> S0=8000.
- A0=0001 and B0=0001 -> S0=0000. A0=ffff and B0=0001 -> S0=ffff (floor truncation). Run with all other operands 0.
- Random in_valid gaps during LOAD; out_ready held 0 for 5 cycles at idx=3, then toggled -> results identical to the no-gap run. No result is skipped or duplicated, and out_data is stable during the stall.
- rst asserted at COMPUTE cycle 10 and again at DRAIN idx=2 -> next cycle all outputs are at reset values. A fresh 24-word load then yields correct results.
